// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous character RAM between the text-display
// fetch path and the CPU bus. The display has absolute priority and a fixed
// two-clock read latency. The CPU uses the cycles the display leaves free,
// through a req/ack handshake. A saturating wait counter flags CPU starvation.
//
// Ports
//   clk_pixel   pixel clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   disp_req    display read request (one-cycle pulse per character cell)
//   disp_addr   display read address, valid with disp_req
//   disp_data   display read data, valid with disp_valid
//   disp_valid  one-cycle pulse, two clocks after disp_req is sampled
//   cpu_req     CPU request level, held until cpu_ack
//   cpu_we      1 = write, 0 = read, held with cpu_req
//   cpu_addr    CPU address, held with cpu_req
//   cpu_wdata   CPU write data, held with cpu_req
//   cpu_rdata   CPU read data, valid in the cpu_ack cycle
//   cpu_ack     one-cycle pulse, two clocks after the grant edge
//   ram_addr    registered RAM address
//   ram_we      registered RAM write enable (one-cycle pulse)
//   ram_wdata   registered RAM write data
//   ram_rdata   RAM read data, valid one clock after ram_addr is presented
//   starve_err  sticky, set when the CPU wait count reaches STARVE_LIMIT
// ---------------------------------------------------------------------------
module vram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 16
) (
   input  logic              clk_pixel,
   input  logic              rst_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              starve_err
);

   // Owner of the RAM access issued on a given cycle, tracked down the
   // two-stage read pipeline so returned data is routed to the right port.
   typedef enum logic [1:0] {
      T_NONE = 2'd0,
      T_DISP = 2'd1,
      T_CPU  = 2'd2
   } tag_t;

   // C_ISSUED: CPU access is on the RAM pins.
   // C_ACK   : RAM is returning the CPU word; cpu_ack fires leaving this state,
   //           which gives the CPU the same two-clock latency as the display.
   typedef enum logic [1:0] {
      C_IDLE   = 2'd0,
      C_ISSUED = 2'd1,
      C_ACK    = 2'd2
   } cpu_state_t;

   localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

   cpu_state_t state, state_next;
   tag_t       tag0, tag1;
   logic       cpu_grant;
   logic       cpu_is_write;   // direction of the access currently in flight
   logic [7:0] wait_cnt, wait_cnt_next;

   // ------------------------------------------------------------------
   // CPU FSM next state, grant decision and wait counter update
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_next    = state;
      cpu_grant     = 1'b0;
      wait_cnt_next = wait_cnt;

      unique case (state)
         C_IDLE: begin
            // The display always wins a collision; the CPU keeps its held
            // request and is granted on the next free cycle.
            if (cpu_req && !disp_req) begin
               cpu_grant  = 1'b1;
               state_next = C_ISSUED;
            end
         end
         C_ISSUED: state_next = C_ACK;
         C_ACK:    state_next = C_IDLE;
         default:  state_next = C_IDLE;
      endcase

      if (!cpu_req || cpu_grant) begin
         wait_cnt_next = '0;
      end else if (state == C_IDLE && wait_cnt != 8'hFF) begin
         wait_cnt_next = wait_cnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state      <= C_IDLE;
         wait_cnt   <= '0;
         starve_err <= 1'b0;
         tag0       <= T_NONE;
         tag1       <= T_NONE;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of its sources, independent of statement order.
         state      <= state_next;
         wait_cnt   <= wait_cnt_next;
         // Set on the same edge the count reaches the limit; sticky.
         starve_err <= starve_err | (wait_cnt_next >= STARVE_LIMIT_C);
         tag1       <= tag0;
         if (disp_req) begin
            tag0 <= T_DISP;
         end else if (cpu_grant) begin
            tag0 <= T_CPU;
         end else begin
            tag0 <= T_NONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Issue stage and data return
   // ------------------------------------------------------------------
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr     <= '0;
         ram_we       <= 1'b0;
         ram_wdata    <= '0;
         cpu_is_write <= 1'b0;
         disp_data    <= '0;
         disp_valid   <= 1'b0;
         cpu_rdata    <= '0;
         cpu_ack      <= 1'b0;
      end else begin
         // One RAM access per clock. ram_we is only ever raised on a CPU
         // grant, so it can never coincide with a display read.
         if (disp_req) begin
            ram_addr <= disp_addr;
            ram_we   <= 1'b0;
         end else if (cpu_grant) begin
            ram_addr     <= cpu_addr;
            ram_we       <= cpu_we;
            ram_wdata    <= cpu_wdata;
            cpu_is_write <= cpu_we;
         end else begin
            ram_we <= 1'b0;
         end

         // tag1 marks the cycle in which ram_rdata holds the word fetched
         // for the access issued two edges ago.
         disp_valid <= (tag1 == T_DISP);
         if (tag1 == T_DISP) begin
            disp_data <= ram_rdata;
         end

         cpu_ack <= (state == C_ACK);
         if (state == C_ACK && !cpu_is_write) begin
            cpu_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. A behavioural synchronous RAM
// (data one clock after the address) sits on the RAM pins. A table of
// directed per-cycle vectors covers display reads, CPU writes/reads,
// collisions and back-to-back display requests; hand-written sequences
// cover reset, held requests, reset during an access and starvation.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   logic              clk_pixel = 1'b0;
   logic              rst_n     = 1'b0;
   logic              disp_req  = 1'b0;
   logic [ADDR_W-1:0] disp_addr = '0;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              cpu_req   = 1'b0;
   logic              cpu_we    = 1'b0;
   logic [ADDR_W-1:0] cpu_addr  = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;
   logic              starve_err;

   int checks   = 0;
   int failures = 0;

   vram_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(16)
   ) dut (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .disp_req  (disp_req),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .disp_valid(disp_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .starve_err(starve_err)
   );

   always #5 clk_pixel = ~clk_pixel;

   // Behavioural 2K x 8 synchronous RAM, read-before-write.
   logic [DATA_W-1:0] mem [0:2047];
   always @(posedge clk_pixel) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic set_in(input logic dr, input logic [10:0] da, input logic cr,
                         input logic cw, input logic [10:0] ca, input logic [7:0] cd);
      disp_req  = dr;
      disp_addr = da;
      cpu_req   = cr;
      cpu_we    = cw;
      cpu_addr  = ca;
      cpu_wdata = cd;
   endtask

   typedef struct {
      logic        d_req;
      logic [10:0] d_addr;
      logic        c_req;
      logic        c_we;
      logic [10:0] c_addr;
      logic [7:0]  c_wdata;
      logic        e_dv;
      logic [7:0]  e_dd;     // compared only when e_dv
      logic        e_ack;
      logic [7:0]  e_rd;     // compared only when e_ack
      logic        e_we;
      logic [10:0] e_addr;
   } vec_t;

   function automatic vec_t mk(input logic dr, input logic [10:0] da, input logic cr,
                               input logic cw, input logic [10:0] ca, input logic [7:0] cd,
                               input logic dv, input logic [7:0] dd, input logic ak,
                               input logic [7:0] rd, input logic we, input logic [10:0] ad);
      vec_t v;
      v.d_req = dr; v.d_addr = da; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
      v.e_dv = dv; v.e_dd = dd; v.e_ack = ak; v.e_rd = rd; v.e_we = we; v.e_addr = ad;
      return v;
   endfunction

   vec_t vecs [35];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;

      //            dreq daddr   creq we caddr   wdata   dv dd     ack rd     we addr
      // CPU write 0x123 <= 0x5A (preload for display)
      vecs[0]  = mk(0, 11'h000, 1, 1, 11'h123, 8'h5A, 0, 8'h00, 0, 8'h00, 1, 11'h123);
      vecs[1]  = mk(0, 11'h000, 1, 1, 11'h123, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 11'h123);
      vecs[2]  = mk(0, 11'h000, 1, 1, 11'h123, 8'h5A, 0, 8'h00, 1, 8'h00, 0, 11'h123);
      vecs[3]  = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h123);
      // Display read of 0x123
      vecs[4]  = mk(1, 11'h123, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h123);
      vecs[5]  = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h123);
      vecs[6]  = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 8'h5A, 0, 8'h00, 0, 11'h123);
      // CPU write 0x7FF <= 0xA5, then read it back (new request in ack cycle)
      vecs[7]  = mk(0, 11'h000, 1, 1, 11'h7FF, 8'hA5, 0, 8'h00, 0, 8'h00, 1, 11'h7FF);
      vecs[8]  = mk(0, 11'h000, 1, 1, 11'h7FF, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 11'h7FF);
      vecs[9]  = mk(0, 11'h000, 1, 1, 11'h7FF, 8'hA5, 0, 8'h00, 1, 8'h00, 0, 11'h7FF);
      vecs[10] = mk(0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h7FF);
      vecs[11] = mk(0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h7FF);
      vecs[12] = mk(0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 11'h7FF);
      vecs[13] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h7FF);
      // Preload 0x020 <= 0x3C and 0x010 <= 0xC3; write acks hold cpu_rdata
      vecs[14] = mk(0, 11'h000, 1, 1, 11'h020, 8'h3C, 0, 8'h00, 0, 8'h00, 1, 11'h020);
      vecs[15] = mk(0, 11'h000, 1, 1, 11'h020, 8'h3C, 0, 8'h00, 0, 8'h00, 0, 11'h020);
      vecs[16] = mk(0, 11'h000, 1, 1, 11'h020, 8'h3C, 0, 8'h00, 1, 8'hA5, 0, 11'h020);
      vecs[17] = mk(0, 11'h000, 1, 1, 11'h010, 8'hC3, 0, 8'h00, 0, 8'h00, 1, 11'h010);
      vecs[18] = mk(0, 11'h000, 1, 1, 11'h010, 8'hC3, 0, 8'h00, 0, 8'h00, 0, 11'h010);
      vecs[19] = mk(0, 11'h000, 1, 1, 11'h010, 8'hC3, 0, 8'h00, 1, 8'hA5, 0, 11'h010);
      vecs[20] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h010);
      // Collision: display 0x010 wins, CPU read 0x020 granted one clock later
      vecs[21] = mk(1, 11'h010, 1, 0, 11'h020, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h010);
      vecs[22] = mk(0, 11'h000, 1, 0, 11'h020, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h020);
      vecs[23] = mk(0, 11'h000, 1, 0, 11'h020, 8'h00, 1, 8'hC3, 0, 8'h00, 0, 11'h020);
      vecs[24] = mk(0, 11'h000, 1, 0, 11'h020, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 11'h020);
      vecs[25] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h020);
      // Display request while a CPU read is in flight keeps its latency
      vecs[26] = mk(0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h7FF);
      vecs[27] = mk(1, 11'h123, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h123);
      vecs[28] = mk(0, 11'h000, 1, 0, 11'h7FF, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 11'h123);
      vecs[29] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 8'h5A, 0, 8'h00, 0, 11'h123);
      // Back-to-back display requests return in order
      vecs[30] = mk(1, 11'h010, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h010);
      vecs[31] = mk(1, 11'h020, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h020);
      vecs[32] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 8'hC3, 0, 8'h00, 0, 11'h020);
      vecs[33] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 11'h020);
      vecs[34] = mk(0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 11'h020);

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk_pixel);
      #1;
      check("rst_disp_valid", disp_valid, 0);
      check("rst_cpu_ack",    cpu_ack,    0);
      check("rst_ram_we",     ram_we,     0);
      check("rst_ram_addr",   ram_addr,   0);
      check("rst_starve",     starve_err, 0);
      rst_n = 1'b1;

      // ---------------- vector table ----------------
      for (int i = 0; i < 35; i++) begin
         set_in(vecs[i].d_req, vecs[i].d_addr, vecs[i].c_req, vecs[i].c_we,
                vecs[i].c_addr, vecs[i].c_wdata);
         tick();
         check($sformatf("v%0d_disp_valid", i), disp_valid, vecs[i].e_dv);
         check($sformatf("v%0d_cpu_ack", i),    cpu_ack,    vecs[i].e_ack);
         check($sformatf("v%0d_ram_we", i),     ram_we,     vecs[i].e_we);
         check($sformatf("v%0d_ram_addr", i),   ram_addr,   vecs[i].e_addr);
         check($sformatf("v%0d_starve", i),     starve_err, 0);
         if (vecs[i].e_dv)  check($sformatf("v%0d_disp_data", i), disp_data, vecs[i].e_dd);
         if (vecs[i].e_ack) check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
      end

      // ---------------- held request: regrant one clock after ack ----------------
      set_in(0, 11'h000, 1, 1, 11'h055, 8'h77);
      tick(); check("held_e0_we", ram_we, 1); check("held_e0_ack", cpu_ack, 0);
      check("held_e0_addr", ram_addr, 11'h055); check("held_e0_wdata", ram_wdata, 8'h77);
      tick(); check("held_e1_we", ram_we, 0); check("held_e1_ack", cpu_ack, 0);
      tick(); check("held_e2_we", ram_we, 0); check("held_e2_ack", cpu_ack, 1);
      tick(); check("held_e3_we", ram_we, 1); check("held_e3_ack", cpu_ack, 0);
      tick(); check("held_e4_we", ram_we, 0); check("held_e4_ack", cpu_ack, 0);
      tick(); check("held_e5_we", ram_we, 0); check("held_e5_ack", cpu_ack, 1);
      set_in(0, 11'h000, 0, 0, 11'h000, 8'h00);
      tick(); check("held_e6_we", ram_we, 0); check("held_e6_ack", cpu_ack, 0);

      // ---------------- reset during C_ISSUED ----------------
      set_in(1, 11'h123, 0, 0, 11'h000, 8'h00);
      tick();
      set_in(0, 11'h000, 1, 0, 11'h020, 8'h00);
      tick();                         // CPU read granted, FSM in C_ISSUED
      check("pre_rst_addr", ram_addr, 11'h020);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ram_addr",   ram_addr,   0);
      check("mid_rst_ram_wdata",  ram_wdata,  0);
      check("mid_rst_ram_we",     ram_we,     0);
      check("mid_rst_disp_data",  disp_data,  0);
      check("mid_rst_disp_valid", disp_valid, 0);
      check("mid_rst_cpu_rdata",  cpu_rdata,  0);
      check("mid_rst_cpu_ack",    cpu_ack,    0);
      set_in(0, 11'h000, 0, 0, 11'h000, 8'h00);
      repeat (2) @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cpu_ack || disp_valid) seen = 1'b1;
      end
      check("post_rst_no_stale_resp", seen, 0);
      set_in(1, 11'h010, 0, 0, 11'h000, 8'h00);
      tick();
      set_in(0, 11'h000, 0, 0, 11'h000, 8'h00);
      tick(); check("post_rst_dv_early", disp_valid, 0);
      tick(); check("post_rst_dv", disp_valid, 1); check("post_rst_dd", disp_data, 8'hC3);

      // ---------------- starvation ----------------
      set_in(1, 11'h123, 1, 0, 11'h020, 8'h00);
      seen = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (cpu_ack) seen = 1'b1;
         if (i == 15) check("starve_at_15", starve_err, 0);
         if (i == 16) check("starve_at_16", starve_err, 1);
      end
      check("starve_no_ack", seen, 0);
      set_in(0, 11'h000, 1, 0, 11'h020, 8'h00);
      tick(); check("starve_grant_addr", ram_addr, 11'h020); check("starve_grant_we", ram_we, 0);
      tick(); check("starve_ack_early", cpu_ack, 0);
      tick(); check("starve_ack", cpu_ack, 1); check("starve_rdata", cpu_rdata, 8'h3C);
      check("starve_sticky_ack", starve_err, 1);
      set_in(0, 11'h000, 0, 0, 11'h000, 8'h00);
      tick(); check("starve_sticky_idle", starve_err, 1); check("starve_ack_drop", cpu_ack, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
